ps2_keyboard_rx: RTL and testbench

PS/2 device-to-host receiver that turns raw keyboard line activity into decoded key events for the CPU's I/O path. It sits directly upstream of the key-detect and I/O logic that feeds the cpu_top datapath. It synchronises PS2_CLK/PS2_DAT, deserialises 11-bit frames and checks framing and parity. It folds E0 (extended) and F0 (break) prefixes into single make/break events and tracks the space-bar state.

---
 rtl/ps2_keyboard_rx_if.sv | 34 +++
 rtl/ps2_keyboard_rx.sv | 144 ++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver bus: raw line inputs and decoded key events.
// master = receiver side, slave = consumer/line-driver side.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       space_is_down;

  modport master (
    input  ps2_clk,
    input  ps2_dat,
    output key_code,
    output key_extended,
    output key_break,
    output key_valid,
    output frame_err,
    output space_is_down
  );

  modport slave (
    output ps2_clk,
    output ps2_dat,
    input  key_code,
    input  key_extended,
    input  key_break,
    input  key_valid,
    input  frame_err,
    input  space_is_down
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: frame deserialiser with
// E0/F0 prefix folding and space-bar state tracking.
module ps2_keyboard_rx #(
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [7:0] SPACE_CODE     = 8'h29
) (
  input logic             clk,
  input logic             reset,
  ps2_keyboard_rx_if.master bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic          clk_s1_q, clk_s2_q, hist_q;
  logic          dat_s1_q, dat_s2_q;
  logic          fall;
  logic          good;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          ext_pend_q, brk_pend_q;
  logic [7:0]    code_q;
  logic          ext_q, brk_q;
  logic          valid_q, err_q;
  logic          space_q;

  assign fall = hist_q & ~clk_s2_q;
  assign good = dat_s2_q & (^sh_q ^ par_q);

  // Two-flop synchronisers plus clock history; idle bus is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      hist_q   <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= bus.ps2_clk;
      clk_s2_q <= clk_s1_q;
      hist_q   <= clk_s2_q;
      dat_s1_q <= bus.ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Frame FSM, timeout, prefix folding and registered key outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      space_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == IDLE || fall)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;

      unique case (state_q)
        IDLE: begin
          if (fall && !dat_s2_q) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            sh_q      <= {dat_s2_q, sh_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7)
              state_q <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state_q <= IDLE;
            unique case (1'b1)
              !good: begin
                err_q      <= 1'b1;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
              end
              sh_q == 8'hF0: brk_pend_q <= 1'b1;
              sh_q == 8'hE0: ext_pend_q <= 1'b1;
              default: begin
                valid_q    <= 1'b1;
                code_q     <= sh_q;
                ext_q      <= ext_pend_q;
                brk_q      <= brk_pend_q;
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
                if (sh_q == SPACE_CODE && !ext_pend_q)
                  space_q <= ~brk_pend_q;
              end
            endcase
          end
        end
      endcase

      // A fall on the terminal count keeps the frame alive.
      if (state_q != IDLE && !fall && tmo_q == TLAST) begin
        state_q    <= IDLE;
        err_q      <= 1'b1;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  assign bus.key_code      = code_q;
  assign bus.key_extended  = ext_q;
  assign bus.key_break     = brk_q;
  assign bus.key_valid     = valid_q;
  assign bus.frame_err     = err_q;
  assign bus.space_is_down = space_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames,
// expected events queued by stimulus, popped by a monitor.
module tb_ps2_keyboard_rx;

  localparam int H = 20;

  typedef struct {
    bit       err;
    bit [7:0] code;
    bit       ext;
    bit       brk;
    bit       spc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   errors;
  int   checks;
  time  t_drv;
  time  t_valid;
  time  t_err;

  ps2_keyboard_rx_if bus();

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES(100),
    .SPACE_CODE    (8'h29)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic exp_t ev(input bit e, input bit [7:0] c,
                              input bit x, input bit b,
                              input bit s);
    exp_t r;
    r.err  = e;
    r.code = c;
    r.ext  = x;
    r.brk  = b;
    r.spc  = s;
    return r;
  endfunction

  // Sends the first nbits of a frame: start, data LSB-first,
  // odd parity (optionally flipped), stop.
  task automatic send(input bit [7:0] d, input bit flip,
                      input int nbits);
    bit [10:0] f;
    f = {1'b1, ~^d ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_dat = f[i];
      tick(H / 2);
      bus.ps2_clk = 1'b0;
      t_drv = $time;
      tick(H);
      bus.ps2_clk = 1'b1;
      tick(H / 2);
    end
    bus.ps2_dat = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_code"}, int'(bus.key_code), 0);
    chk({nm, "_ext"}, int'(bus.key_extended), 0);
    chk({nm, "_brk"}, int'(bus.key_break), 0);
    chk({nm, "_valid"}, int'(bus.key_valid), 0);
    chk({nm, "_err"}, int'(bus.frame_err), 0);
    chk({nm, "_space"}, int'(bus.space_is_down), 0);
  endtask

  // Monitor: pops one expectation per output event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (bus.key_valid || bus.frame_err)) begin
        if (bus.key_valid) t_valid = $time;
        if (bus.frame_err) t_err = $time;
        if (bus.key_valid && bus.frame_err)
          chk("both_pulses", 1, 0);
        if (q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = q.pop_front();
          chk("ev_valid", int'(bus.key_valid), int'(!e.err));
          chk("ev_err", int'(bus.frame_err), int'(e.err));
          chk("ev_code", int'(bus.key_code), int'(e.code));
          chk("ev_ext", int'(bus.key_extended), int'(e.ext));
          chk("ev_brk", int'(bus.key_break), int'(e.brk));
          chk("ev_space", int'(bus.space_is_down), int'(e.spc));
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    t_valid = 0;
    t_err = 0;
    reset = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_dat = 1'b1;
    tick(5);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    tick(10);

    q.push_back(ev(0, 8'h1C, 0, 0, 0));
    send(8'h1C, 0, 11);
    chk("valid_latency", int'((t_valid - t_drv) / 10), 3);

    q.push_back(ev(0, 8'h29, 0, 0, 1));
    send(8'h29, 0, 11);
    send(8'hF0, 0, 11);
    q.push_back(ev(0, 8'h29, 0, 1, 0));
    send(8'h29, 0, 11);

    send(8'hE0, 0, 11);
    q.push_back(ev(0, 8'h75, 1, 0, 0));
    send(8'h75, 0, 11);
    send(8'hE0, 0, 11);
    send(8'hF0, 0, 11);
    q.push_back(ev(0, 8'h75, 1, 1, 0));
    send(8'h75, 0, 11);

    send(8'hF0, 0, 11);
    q.push_back(ev(1, 8'h75, 1, 1, 0));
    send(8'h1C, 1, 11);
    q.push_back(ev(0, 8'h1C, 0, 0, 0));
    send(8'h1C, 0, 11);

    q.push_back(ev(1, 8'h1C, 0, 0, 0));
    send(8'h33, 0, 5);
    tick(150);
    chk("timeout_latency", int'((t_err - t_drv) / 10), 103);
    q.push_back(ev(0, 8'h5A, 0, 0, 0));
    send(8'h5A, 0, 11);

    q.push_back(ev(0, 8'h29, 0, 0, 1));
    send(8'h29, 0, 11);
    send(8'h1C, 0, 6);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("midreset");
    tick(20);
    q.push_back(ev(0, 8'h29, 0, 0, 1));
    send(8'h29, 0, 11);

    for (int i = 0; i < 200 && q.size() != 0; i++)
      tick(1);
    tick(5);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
